ct_f_spsram_gen: RTL and testbench
==================================

Name: ct_f_spsram_gen

Overview:
- Generic FPGA single-port SRAM wrapper for the C910 FPGA build.
- Keeps the active-low macro interface of the fixed-size SRAM wrappers: CEN, GWEN, per-bit WEN.
- Adds parametrised depth and width, an optional output pipeline register, and a BUSY status output.
- Adds a self-clearing initialisation sweep that fills every entry with INIT_VALUE after reset or on request, so caches and tag arrays need no software clear.

Parameters:
- ADDR_WIDTH, 10: address bits.
- DEPTH, 2**ADDR_WIDTH: number of entries; must be <= 2**ADDR_WIDTH and >= 2.
- DATA_WIDTH, 144: word width in bits.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- INIT_VALUE, '0: DATA_WIDTH-bit value written by the init sweep.

Ports:
- CLK  in  1  clock; all state is on the rising edge.
- cpurst_b  in  1  asynchronous, active-low reset.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low.
- WEN  in  DATA_WIDTH  per-bit write enable, active low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- INIT_REQ  in  1  single-cycle request to re-run the init sweep.
- BUSY  out  1  init sweep in progress; host accesses are ignored while high.

Behaviour:
- Access condition: an access occurs in a cycle with CEN=0 and BUSY=0.
- Write: bit i is written when CEN=0, GWEN=0, WEN[i]=0. Bits with WEN[i]=1 keep their old value.
- Read: addr_hold captures A on every access, read or write.
  - OUT_REG=0: Q = mem[addr_hold] from the cycle after the access.
  - OUT_REG=1: same value, one cycle later.
- Write-through: after a write, Q shows the merged new word with the same latency as a read.
- Hold: while CEN=1, Q holds mem[addr_hold]. Q follows any later write to that address (only the sweep can write while the host is idle).
- Out-of-range address: A >= DEPTH is ignored for writes; Q = INIT_VALUE.
- Reset values:
  - addr_hold = 0.
  - Output register (OUT_REG=1) = INIT_VALUE.
  - BUSY = 1 if CT_F_SPSRAM_INIT_EN is defined, else 0.
  - Q is undefined until the first access or the end of the sweep.
- FSM states (CT_F_SPSRAM_INIT_EN only): INIT and READY. Reset enters INIT with sweep counter cnt = 0.
  - INIT: write INIT_VALUE to mem[cnt] every cycle, all bits enabled. cnt increments. At cnt == DEPTH-1, write that last entry, then go to READY next cycle.
  - BUSY = 1 exactly while in INIT; a sweep takes DEPTH cycles.
  - READY: INIT_REQ=1 moves to INIT with cnt = 0 on the next cycle. An access presented in the same cycle as INIT_REQ is still performed.
  - INIT_REQ while in INIT is ignored; the sweep does not restart.
  - Asynchronous reset mid-sweep: restart from cnt = 0.
- Host accesses during BUSY are dropped silently; no stall and no queueing. addr_hold is unchanged.
- Leaving INIT: addr_hold is forced to 0, so Q = INIT_VALUE in the first READY cycle (latency-adjusted for OUT_REG).
- Sweep counter: ADDR_WIDTH bits, no wrap beyond DEPTH-1.

Optional Feature:
- Macro: CT_F_SPSRAM_INIT_EN.
- Defined: the INIT/READY FSM, sweep counter and BUSY logic are present, as described above.
- Undefined:
  - No FSM; BUSY tied to 0; INIT_REQ unused.
  - Memory content after reset is undefined (X in simulation).
  - All other behaviour is unchanged.

Decomposition:
- Package ct_f_spsram_pkg:
  - state enum {INIT, READY}.
  - Read-latency localparam function of OUT_REG.
  - Clog2 helper.
- One sub-module, ct_f_spsram_gen_array:
  - Behavioural storage array with per-bit write mask and synchronous read port.
  - Inferred as block RAM.
  - The top-level holds the FSM, address mux (sweep vs host), addr_hold and output register.

Test Plan:
- Init sweep (DEPTH=16, INIT_VALUE=0xA5 replicated, macro on): release reset -> BUSY=1 for exactly 16 cycles; reading every address afterwards -> 0xA5.. pattern.
- Masked write (OUT_REG=0): write 0 to addr 3, then D=all-ones with WEN[7:0]=0 at addr 3 -> Q=0x...00FF one cycle later; with OUT_REG=1 the same value two cycles later.
- Hold: read addr 5 (holding 0x1234), then CEN=1 for 10 cycles -> Q stays 0x1234; with GWEN=1, Q is unchanged by any D/WEN activity.
- Access during BUSY: pulse INIT_REQ, then write 0xFFFF to addr 2 in sweep cycle 1 -> write dropped; addr 2 reads INIT_VALUE after BUSY falls (sweep length DEPTH).
- Reset mid-sweep: assert cpurst_b low at sweep cycle 7 -> after release, BUSY high for a full DEPTH cycles and all entries read INIT_VALUE.
- Macro off: BUSY=0 from reset; INIT_REQ pulse has no effect; write then read addr DEPTH-1 -> written data returned.

Source files
------------

// File: rtl/ct_f_spsram_pkg.sv
// ct_f_spsram_pkg: shared types and helpers for the generic single-port SRAM wrapper.
//   sram_state_e  : init-sweep FSM states (INIT, READY).
//   read_latency(): read latency in cycles for a given OUT_REG setting.
//   ct_clog2()    : ceil(log2(value)), used to size the storage index.
package ct_f_spsram_pkg;

  typedef enum logic {
    INIT,
    READY
  } sram_state_e;

  function automatic int unsigned read_latency(input int unsigned out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

  function automatic int unsigned ct_clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ct_f_spsram_gen_array.sv
// ct_f_spsram_gen_array: behavioural storage array for ct_f_spsram_gen.
//   CLK     : clock (writes on rising edge)
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_mask : per-bit write enable, active high
//   wr_data : write data
//   rd_addr : read index, driven from a register in the parent so the pair
//             (registered address, array lookup) maps onto a block RAM port
//   rd_data : mem[rd_addr]
// The array has no reset; its contents are whatever was last written.
module ct_f_spsram_gen_array
  import ct_f_spsram_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned IDX_WIDTH  = ct_clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ct_f_spsram_gen.sv
// ct_f_spsram_gen: generic single-port SRAM wrapper with active-low macro interface.
//   CLK      : clock, all state on rising edge
//   cpurst_b : asynchronous active-low reset
//   A        : access address
//   CEN      : chip enable, active low
//   GWEN     : global write enable, active low
//   WEN      : per-bit write enable, active low
//   D        : write data
//   Q        : read data (latency 1, or 2 with OUT_REG=1)
//   INIT_REQ : single-cycle request to re-run the init sweep
//   BUSY     : init sweep in progress; host accesses are dropped while high
// Build option: define CT_F_SPSRAM_INIT_EN to include the INIT/READY sweep FSM that fills
// every entry with INIT_VALUE after reset or on INIT_REQ. Without it BUSY is tied low,
// INIT_REQ is ignored and memory content after reset is undefined.
module ct_f_spsram_gen
  import ct_f_spsram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DEPTH      = 2 ** ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = 144,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  INIT_REQ,
  output logic                  BUSY
);

  localparam int unsigned     IdxW        = ct_clog2(DEPTH);
  localparam int unsigned     ReadLatency = read_latency(OUT_REG);
  localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  host_acc;
  logic                  host_wr;
  logic                  a_in_range;
  logic                  hold_in_range;
  logic                  sweep_wr;
  logic                  sweep_done;
  logic [IdxW-1:0]       sweep_idx;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  arr_wr_en;
  logic [IdxW-1:0]       arr_wr_addr;
  logic [DATA_WIDTH-1:0] arr_wr_mask;
  logic [DATA_WIDTH-1:0] arr_wr_data;
  logic [DATA_WIDTH-1:0] arr_rd_data;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef CT_F_SPSRAM_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LastIdx) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        // A host access in the same cycle is still performed (BUSY is low now).
        if (INIT_REQ) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    BUSY       = (state_q == INIT);
    sweep_wr   = (state_q == INIT);
    sweep_done = (state_q == INIT) && (cnt_q == LastIdx);
    sweep_idx  = cnt_q[IdxW-1:0];
  end
`else
  logic unused_init_req;
  assign unused_init_req = INIT_REQ;

  always_comb begin
    BUSY       = 1'b0;
    sweep_wr   = 1'b0;
    sweep_done = 1'b0;
    sweep_idx  = '0;
  end
`endif

  assign host_acc      = !CEN && !BUSY;
  assign host_wr       = host_acc && !GWEN;
  assign a_in_range    = ({1'b0, A} < DepthW);
  assign hold_in_range = ({1'b0, addr_hold_q} < DepthW);

  // Leaving the sweep parks the read address at 0 so Q shows INIT_VALUE.
  always_comb begin
    addr_hold_d = addr_hold_q;
    if (sweep_done) begin
      addr_hold_d = '0;
    end else if (host_acc) begin
      addr_hold_d = A;
    end
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      addr_hold_q <= '0;
    end else begin
      addr_hold_q <= addr_hold_d;
    end
  end

  // The sweep owns the write port while it runs; host writes are blocked by BUSY.
  always_comb begin
    if (sweep_wr) begin
      arr_wr_en   = 1'b1;
      arr_wr_addr = sweep_idx;
      arr_wr_mask = '1;
      arr_wr_data = INIT_VALUE;
    end else begin
      arr_wr_en   = host_wr && a_in_range;
      arr_wr_addr = A[IdxW-1:0];
      arr_wr_mask = ~WEN;
      arr_wr_data = D;
    end
  end

  ct_f_spsram_gen_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IdxW)
  ) u_array (
    .CLK     (CLK),
    .wr_en   (arr_wr_en),
    .wr_addr (arr_wr_addr),
    .wr_mask (arr_wr_mask),
    .wr_data (arr_wr_data),
    .rd_addr (addr_hold_q[IdxW-1:0]),
    .rd_data (arr_rd_data)
  );

  assign rd_word = hold_in_range ? arr_rd_data : INIT_VALUE;

  if (ReadLatency == 2) begin : gen_out_reg
    logic [DATA_WIDTH-1:0] q_out_q;

    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        q_out_q <= INIT_VALUE;
      end else begin
        q_out_q <= rd_word;
      end
    end

    assign Q = q_out_q;
  end else begin : gen_out_comb
    assign Q = rd_word;
  end

endmodule

// File: tb/tb_ct_f_spsram_gen.sv
// Testbench for ct_f_spsram_gen: two instances (OUT_REG=0 and OUT_REG=1) share one stimulus
// stream. A behavioural model predicts BUSY and Q (with a known-bit mask for undefined data)
// after every clock edge and pushes the prediction into per-instance queues; a monitor on the
// falling edge pops and compares.
module tb_ct_f_spsram_gen;

  localparam int          AW    = 5;
  localparam int          DEPTH = 16;
  localparam int          DW    = 16;
  localparam logic [15:0] INITV = 16'hA5A5;
`ifdef CT_F_SPSRAM_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] mask;
    logic          busy;
  } exp_t;

  logic          CLK;
  logic          cpurst_b;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic          INIT_REQ;
  logic [DW-1:0] Q0, Q1;
  logic          BUSY0, BUSY1;

  int n_cmp = 0;
  int n_err = 0;

  exp_t exp0_q[$];
  exp_t exp1_q[$];

  // Reference model state
  logic [DW-1:0] m_mem   [DEPTH];
  logic [DW-1:0] m_known [DEPTH];
  int            m_addr;
  int            busy_left;
  exp_t          prev0;

  ct_f_spsram_gen #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .OUT_REG    (0),
    .INIT_VALUE (INITV)
  ) dut0 (
    .CLK      (CLK),
    .cpurst_b (cpurst_b),
    .A        (A),
    .CEN      (CEN),
    .GWEN     (GWEN),
    .WEN      (WEN),
    .D        (D),
    .Q        (Q0),
    .INIT_REQ (INIT_REQ),
    .BUSY     (BUSY0)
  );

  ct_f_spsram_gen #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .OUT_REG    (1),
    .INIT_VALUE (INITV)
  ) dut1 (
    .CLK      (CLK),
    .cpurst_b (cpurst_b),
    .A        (A),
    .CEN      (CEN),
    .GWEN     (GWEN),
    .WEN      (WEN),
    .D        (D),
    .Q        (Q1),
    .INIT_REQ (INIT_REQ),
    .BUSY     (BUSY1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [DW-1:0] q, input logic busy,
                       input exp_t e);
    n_cmp++;
    if (busy !== e.busy) begin
      n_err++;
      $display("FAIL %s busy at %0t: got %b expected %b", name, $time, busy, e.busy);
    end
    if (e.mask != '0) begin
      n_cmp++;
      if ((q & e.mask) !== (e.q & e.mask)) begin
        n_err++;
        $display("FAIL %s q at %0t: got %h expected %h (known bits %h)", name, $time, q, e.q,
                 e.mask);
      end
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      check("lat1", Q0, BUSY0, e);
    end
    if (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      check("lat2", Q1, BUSY1, e);
    end
  end

  task automatic start_sweep();
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = INITV;
      m_known[i] = '1;
    end
  endtask

  // Effect of one rising edge on the model, given the inputs presented before it.
  task automatic model_edge(input logic cen, input logic gwen, input logic [DW-1:0] wen,
                            input logic [DW-1:0] d, input logic [AW-1:0] a, input logic req);
    exp_t e0, e1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) m_addr = 0;
    end else begin
      if (!cen) begin
        m_addr = int'(a);
        if (!gwen && m_addr < DEPTH) begin
          m_mem[m_addr]   = (m_mem[m_addr] & wen) | (d & ~wen);
          m_known[m_addr] = m_known[m_addr] | ~wen;
        end
      end
      if (InitEn && req) start_sweep();
    end
    e0.busy = (busy_left > 0);
    if (e0.busy) begin
      e0.q    = '0;
      e0.mask = '0;
    end else if (m_addr >= DEPTH) begin
      e0.q    = INITV;
      e0.mask = '1;
    end else begin
      e0.q    = m_mem[m_addr];
      e0.mask = m_known[m_addr];
    end
    e1      = prev0;
    e1.busy = e0.busy;
    prev0   = e0;
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
  endtask

  task automatic cyc(input logic cen, input logic gwen, input logic [DW-1:0] wen,
                     input logic [DW-1:0] d, input logic [AW-1:0] a, input logic req);
    CEN      = cen;
    GWEN     = gwen;
    WEN      = wen;
    D        = d;
    A        = a;
    INIT_REQ = req;
    @(posedge CLK);
    model_edge(cen, gwen, wen, d, a, req);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, '1, 16'h0, '0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
    cyc(1'b0, 1'b0, wen, d, AW'(a), 1'b0);
  endtask

  task automatic rd(input int a);
    cyc(1'b0, 1'b1, '1, 16'($urandom), AW'(a), 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    #1;
    cpurst_b = 1'b0;
    CEN      = 1'b1;
    INIT_REQ = 1'b0;
    m_addr   = 0;
    if (InitEn) begin
      start_sweep();
    end else begin
      busy_left = 0;
      for (int i = 0; i < DEPTH; i++) m_known[i] = '0;
    end
    prev0 = '{q: '0, mask: '0, busy: InitEn};
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      exp0_q.push_back('{q: '0, mask: '0, busy: InitEn});
      exp1_q.push_back('{q: INITV, mask: '1, busy: InitEn});
    end
    #1;
    cpurst_b = 1'b1;
  endtask

  initial begin
    cpurst_b = 1'b1;
    A        = '0;
    CEN      = 1'b1;
    GWEN     = 1'b1;
    WEN      = '1;
    D        = '0;
    INIT_REQ = 1'b0;
    m_addr   = 0;
    busy_left = 0;
    prev0    = '{q: '0, mask: '0, busy: 1'b0};
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = '0;
    end
    #2;

    // Reset, then the power-up sweep (if built in)
    do_reset(3);
    idle(DEPTH + 2);
    for (int i = 0; i < DEPTH; i++) rd(i);

    // Out-of-range reads and writes; a write to 20 must not alias onto 4
    rd(16);
    rd(31);
    wr(4, 16'h1111, '0);
    wr(20, 16'hBEEF, '0);
    rd(20);
    rd(4);

    // Masked write and write-through
    wr(3, 16'h0000, '0);
    wr(3, 16'hFFFF, 16'hFF00);
    idle(2);
    rd(3);

    // Hold: idle and GWEN=1 activity must not change Q
    wr(5, 16'h1234, '0);
    rd(5);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), AW'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'($urandom), 16'($urandom), AW'(5), 1'b0);

    // INIT_REQ with a concurrent read, a write dropped in sweep cycle 1, a mid-sweep request
    cyc(1'b0, 1'b1, '1, 16'h0, AW'(5), 1'b1);
    wr(2, 16'hFFFF, '0);
    idle(4);
    cyc(1'b1, 1'b1, '1, 16'h0, '0, 1'b1);
    idle(DEPTH);
    rd(2);
    rd(5);

    // Reset in sweep cycle 7
    wr(7, 16'h7777, '0);
    cyc(1'b1, 1'b1, '1, 16'h0, '0, 1'b1);
    idle(6);
    do_reset(2);
    idle(DEPTH + 2);
    for (int i = 0; i < DEPTH; i++) rd(i);

    // Last entry
    wr(DEPTH - 1, 16'h5A3C, '0);
    rd(DEPTH - 1);
    rd(0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] wen;
      case ($urandom_range(0, 2))
        0:       wen = '0;
        1:       wen = '1;
        default: wen = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 3) == 0), 1'($urandom), wen, 16'($urandom),
          AW'($urandom_range(0, 19)), ($urandom_range(0, 39) == 0));
    end

    idle(DEPTH + 4);
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
